// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER memory-side blocks: line-fill FSM
// states, default line geometry and the line-alignment function.
package otter_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_RD    = 3'd2,
        ST_FILL  = 3'd3,
        ST_ERROR = 3'd4
    } line_fill_state_t;

    localparam int unsigned WORDS_PER_LINE_DEFAULT = 4;
    localparam int unsigned LINE_OFFSET_BITS       = $clog2(4 * WORDS_PER_LINE_DEFAULT);

    // Clears the byte-offset bits of a line address.
    function automatic logic [31:0] line_align(input logic [31:0] addr,
                                               input int unsigned offset_bits);
        logic [31:0] mask;
        mask = (32'd1 << offset_bits) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/line_fill_watchdog.sv
// Beat watchdog for otter_line_fill: counts cycles a burst beat waits for its
// ack and flags expiry on the edge the count would reach TIMEOUT.
module line_fill_watchdog #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = active_i && !ack_i && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || ack_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/otter_line_fill.sv
// Cache-line refill/writeback engine: optional victim burst, line read burst,
// single-cycle fill pulse. Macro LINE_FILL_WATCHDOG_EN adds the beat watchdog.
module otter_line_fill
    import otter_mem_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEFAULT,
    parameter int unsigned TIMEOUT        = 256
) (
    input  logic                          MEM_CLK,
    input  logic                          MEM_RST_N,
    input  logic                          REQ_VALID,
    output logic                          REQ_READY,
    input  logic [31:0]                   REQ_ADDR,
    input  logic                          REQ_WB,
    input  logic [31:0]                   REQ_WB_ADDR,
    input  logic [32*WORDS_PER_LINE-1:0]  REQ_WB_LINE,
    output logic                          FILL_VALID,
    output logic [31:0]                   FILL_ADDR,
    output logic [32*WORDS_PER_LINE-1:0]  FILL_LINE,
    output logic [31:0]                   MM_ADDR,
    output logic                          MM_RDEN,
    output logic                          MM_WE,
    output logic [31:0]                   MM_DOUT,
    input  logic [31:0]                   MM_DIN,
    input  logic                          MM_ACK,
    output logic                          ERR
);

    localparam int unsigned BEAT_W      = $clog2(WORDS_PER_LINE);
    localparam int unsigned LINE_W      = 32 * WORDS_PER_LINE;
    localparam int unsigned OFFSET_BITS = $clog2(4 * WORDS_PER_LINE);

    if (WORDS_PER_LINE < 2 || (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0 || TIMEOUT < 1)
    begin : g_bad_cfg
        $error("otter_line_fill: WORDS_PER_LINE must be a power of two >= 2, TIMEOUT >= 1");
    end

    line_fill_state_t    state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         wb_base_q, wb_base_d;
    logic [LINE_W-1:0]   victim_q, victim_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                ready_q, ready_d;
    logic                fill_valid_q, fill_valid_d;
    logic [31:0]         fill_addr_q, fill_addr_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;
    logic [31:0]         mm_addr_q, mm_addr_d;
    logic                mm_rden_q, mm_rden_d;
    logic                mm_we_q, mm_we_d;
    logic [31:0]         mm_dout_q, mm_dout_d;
    logic                err_q, err_d;

    logic [BEAT_W-1:0]   beat_inc;
    logic                last_beat;
    logic                wd_expired;

    assign beat_inc  = beat_q + BEAT_W'(1);
    assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

`ifdef LINE_FILL_WATCHDOG_EN
    logic in_burst;
    assign in_burst = (state_q == ST_WB) || (state_q == ST_RD);

    line_fill_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .clk       (MEM_CLK),
        .rst_n     (MEM_RST_N),
        .active_i  (in_burst),
        .ack_i     (MM_ACK),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        wb_base_d    = wb_base_q;
        victim_d     = victim_q;
        line_d       = line_q;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_line_d  = fill_line_q;
        mm_addr_d    = mm_addr_q;
        mm_rden_d    = 1'b0;
        mm_we_d      = 1'b0;
        mm_dout_d    = mm_dout_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    base_d    = line_align(REQ_ADDR, OFFSET_BITS);
                    wb_base_d = line_align(REQ_WB_ADDR, OFFSET_BITS);
                    victim_d  = REQ_WB_LINE;
                    beat_d    = '0;
                    if (REQ_WB) begin
                        state_d   = ST_WB;
                        mm_we_d   = 1'b1;
                        mm_addr_d = line_align(REQ_WB_ADDR, OFFSET_BITS);
                        mm_dout_d = REQ_WB_LINE[31:0];
                    end else begin
                        state_d   = ST_RD;
                        mm_rden_d = 1'b1;
                        mm_addr_d = line_align(REQ_ADDR, OFFSET_BITS);
                    end
                end
            end
            ST_WB: begin
                mm_we_d = 1'b1;
                if (MM_ACK) begin
                    beat_d = beat_inc;
                    if (last_beat) begin
                        state_d   = ST_RD;
                        mm_we_d   = 1'b0;
                        mm_rden_d = 1'b1;
                        mm_addr_d = base_q;
                    end else begin
                        mm_addr_d = wb_base_q + (32'(beat_inc) << 2);
                        mm_dout_d = victim_q[beat_inc*32 +: 32];
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERROR;
                    mm_we_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_RD: begin
                mm_rden_d = 1'b1;
                if (MM_ACK) begin
                    line_d[beat_q*32 +: 32] = MM_DIN;
                    beat_d = beat_inc;
                    if (last_beat) begin
                        state_d      = ST_FILL;
                        mm_rden_d    = 1'b0;
                        fill_valid_d = 1'b1;
                        fill_addr_d  = base_q;
                        fill_line_d  = line_d;
                    end else begin
                        mm_addr_d = base_q + (32'(beat_inc) << 2);
                    end
                end else if (wd_expired) begin
                    state_d   = ST_ERROR;
                    mm_rden_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: the victim and line buffers are reset along with the control state
    // so a burst aborted by reset can never leak partial data into a later fill.
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            wb_base_q    <= '0;
            victim_q     <= '0;
            line_q       <= '0;
            ready_q      <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_line_q  <= '0;
            mm_addr_q    <= '0;
            mm_rden_q    <= 1'b0;
            mm_we_q      <= 1'b0;
            mm_dout_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            wb_base_q    <= wb_base_d;
            victim_q     <= victim_d;
            line_q       <= line_d;
            ready_q      <= ready_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_line_q  <= fill_line_d;
            mm_addr_q    <= mm_addr_d;
            mm_rden_q    <= mm_rden_d;
            mm_we_q      <= mm_we_d;
            mm_dout_q    <= mm_dout_d;
            err_q        <= err_d;
        end
    end

    assign REQ_READY  = ready_q;
    assign FILL_VALID = fill_valid_q;
    assign FILL_ADDR  = fill_addr_q;
    assign FILL_LINE  = fill_line_q;
    assign MM_ADDR    = mm_addr_q;
    assign MM_RDEN    = mm_rden_q;
    assign MM_WE      = mm_we_q;
    assign MM_DOUT    = mm_dout_q;
    assign ERR        = err_q;

endmodule

// File: doc/otter_line_fill.md
# otter_line_fill

Cache-line refill/writeback engine between the OTTER data cache and word-wide backing memory. On a miss the cache hands over a line address and, if the victim is dirty, the victim line. The block bursts the victim out word by word, then reads the new line word by word, and returns it in one fill pulse. It is the stage directly downstream of the cache in OtterMemory and is the source of the memory-side stall behind MEM_VALID2 and ERR.

## Interface
- WORDS_PER_LINE, 4, words per cache line; power of two, ≥2
- TIMEOUT, 256, max cycles a beat may wait for MM_ACK (used only with watchdog)
- MEM_CLK  in  1  clock; all logic on rising edge
- MEM_RST_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  cache requests a line transaction
- REQ_READY  out  1  block idle and able to accept a request
- REQ_ADDR  in  32  byte address of missed line; offset bits ignored
- REQ_WB  in  1  victim is dirty; write it back first
- REQ_WB_ADDR  in  32  byte address of victim line; offset bits ignored
- REQ_WB_LINE  in  32*WORDS_PER_LINE  victim data; word 0 in bits [31:0]
- FILL_VALID  out  1  one-cycle pulse; FILL_LINE/FILL_ADDR valid
- FILL_ADDR  out  32  line-aligned address of the returned line
- FILL_LINE  out  32*WORDS_PER_LINE  returned line; word 0 in bits [31:0]
- MM_ADDR  out  32  word-aligned backing-memory address
- MM_RDEN  out  1  read beat request
- MM_WE  out  1  write beat request
- MM_DOUT  out  32  write data
- MM_DIN  in  32  read data, valid in the MM_ACK cycle
- MM_ACK  in  1  current beat complete
- ERR  out  1  sticky watchdog error

## Operation
- States: IDLE, WB, RD, FILL, ERROR.
- IDLE: REQ_READY=1. On REQ_VALID&REQ_READY, capture both addresses with offset bits cleared to base = addr & ~(4*WORDS_PER_LINE-1). Also capture REQ_WB_LINE and clear beat. Go to WB if REQ_WB, else RD.
- WB: MM_WE=1, MM_ADDR=wb_base+4*beat, MM_DOUT=victim word[beat]. On MM_ACK, beat++. Ack on last beat: beat=0, go to RD.
- RD: MM_RDEN=1, MM_ADDR=base+4*beat. On MM_ACK, store MM_DIN into word[beat] and beat++. Ack on last beat: go to FILL.
- FILL: FILL_VALID=1 for exactly one cycle, then IDLE. The cache may not backpressure.
- Beat counter is $clog2(WORDS_PER_LINE) bits and wraps to 0 after the last beat.
- MM_ACK is ignored in IDLE, FILL and ERROR.
- MM_WE and MM_RDEN are never high together.
- Request inputs are ignored outside IDLE.

## Timing
- Reset (MEM_RST_N low, asynchronous) forces:
  - state IDLE, beat 0, watchdog 0
  - all outputs 0, including REQ_READY (gated low while in reset)
  - FILL_LINE, FILL_ADDR, MM_ADDR, MM_DOUT at 0
- REQ_READY is 1 from the first edge after reset release.
- All MM_* and FILL_* outputs are registered.
- The first beat is presented on the cycle after acceptance.
- Each beat holds address, data and strobe stable until the MM_ACK cycle. The next beat appears the cycle after the ack. Back-to-back acks give one beat per cycle.
- With a zero-wait memory (ack every cycle):
  - clean miss: FILL_VALID on cycle 1+WORDS_PER_LINE after acceptance
  - dirty miss: FILL_VALID on cycle 1+2*WORDS_PER_LINE
- FILL_LINE and FILL_ADDR hold their values after the pulse until the next FILL.
- A new request is accepted at the earliest on the cycle after FILL.
- Reset mid-burst aborts immediately. No FILL is produced and partial data is discarded.

## Configuration
- LINE_FILL_WATCHDOG_EN defined:
  - A counter tracks cycles spent in WB/RD without MM_ACK. It resets to 0 on each ack and on each state entry.
  - When the count reaches TIMEOUT: go to ERROR, set ERR=1, drop MM_WE/MM_RDEN the same edge, hold REQ_READY=0.
  - ERROR and ERR persist until reset.
- Not defined: no counter; a beat waits for MM_ACK indefinitely; ERR tied 0 and the ERROR state is unreachable.

## Structure
- Package otter_mem_pkg holds:
  - line_fill_state_t enum
  - default WORDS_PER_LINE
  - LINE_OFFSET_BITS = $clog2(4*WORDS_PER_LINE)
  - line-alignment helper function
- One sub-module, line_fill_watchdog (counter plus compare). It is instantiated only under LINE_FILL_WATCHDOG_EN.

## Test plan
- Clean miss, REQ_ADDR=0x0000_1234, zero-wait memory returning 0x1000+addr -> reads at 0x1230, 0x1234, 0x1238, 0x123C. FILL_ADDR=0x1230 and FILL_LINE words {0x2230, 0x2234, 0x2238, 0x223C}. FILL_VALID is 1 cycle wide, on cycle 5 after acceptance.
- Dirty miss, REQ_WB_ADDR=0x0000_8004, victim {A0,A1,A2,A3}, REQ_ADDR=0x40 -> four writes to 0x8000..0x800C with MM_DOUT A0..A3 first, then four reads from 0x40..0x4C. FILL_VALID on cycle 9.
- Memory acks every third cycle -> each beat's MM_ADDR/MM_DOUT/strobe stays stable until its ack. The result matches the zero-wait case.
- Assert MEM_RST_N low during RD beat 2 -> all outputs 0 asynchronously and no FILL_VALID. After release, REQ_READY=1 and a new miss completes normally.
- With LINE_FILL_WATCHDOG_EN and TIMEOUT=8, memory never acks -> ERR rises 8 cycles after the first beat and MM_RDEN drops. REQ_READY stays 0 and ERR holds until reset.
